// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bundle shared by the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        FnACC = 4'd0,
        FnMem = 4'd1,
        FnADD = 4'd2,
        FnSUB = 4'd3,
        FnAND = 4'd4,
        FnOR  = 4'd5,
        FnNOT = 4'd6,
        FnLSL = 4'd7,
        FnLSR = 4'd8,
        FnADC = 4'd9,
        FnSBC = 4'd10
    } alu_functions_t;

    typedef enum logic [1:0] {
        AluIdle,
        AluShift,
        AluDone
    } alu_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_addsub.sv
// alu_addsub: shared adder for ADD/ADC/SUB/SBC; subtraction inverts b and relies on cin.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] bx;

    assign bx          = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    assign ovf         = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/ready/done handshake, bit-serial shifter and registered flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [3:0]         Func,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               CarryIn,
    input  logic [SHAMT_W-1:0] ShAmt,
    output logic               Ready,
    output logic               Done,
    output logic [WIDTH-1:0]   Result,
    output logic               FlagZ,
    output logic               FlagN,
    output logic               FlagC,
    output logic               FlagV
);
    alu_state_t state, stateNext;
    alu_flags_t flags, oneFlags, shiftFlags;
    logic [WIDTH-1:0]   acc, accNext, oneRes, sum;
    logic [SHAMT_W-1:0] cnt;
    logic shLeft, bitOut, accept, isShift, lastShift;
    logic addCin, isSub, cout, ovf, oneC, oneV;

    alu_addsub #(.WIDTH(WIDTH)) uAddSub (
        .a(A), .b(B), .cin(addCin), .sub(isSub), .sum(sum), .cout(cout), .ovf(ovf)
    );

    assign accept    = Start && Ready;
    assign isShift   = (Func == FnLSL || Func == FnLSR) && ShAmt != '0;
    assign lastShift = state == AluShift && cnt == SHAMT_W'(1);
    assign isSub     = Func == FnSUB || Func == FnSBC;
    assign addCin    = Func == FnADD ? 1'b0 : Func == FnSUB ? 1'b1 : CarryIn;
    assign accNext   = shLeft ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    assign bitOut    = shLeft ? acc[WIDTH-1] : acc[0];

    // Zero-distance shifts and undefined codes fall into the pass-through default.
    always_comb begin
        oneRes = A;
        oneC   = 1'b0;
        oneV   = 1'b0;
        case (Func)
            FnMem:                      oneRes = B;
            FnADD, FnSUB, FnADC, FnSBC: begin oneRes = sum; oneC = cout; oneV = ovf; end
            FnAND:                      oneRes = A & B;
            FnOR:                       oneRes = A | B;
            FnNOT:                      oneRes = ~A;
            default:                    oneRes = A;
        endcase
    end

    assign oneFlags   = '{z: oneRes == '0, n: oneRes[WIDTH-1], c: oneC, v: oneV};
    assign shiftFlags = '{z: accNext == '0, n: accNext[WIDTH-1], c: bitOut, v: 1'b0};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= AluIdle;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = accept ? (isShift ? AluShift : AluDone)
                  : state == AluShift ? (lastShift ? AluDone : AluShift)
                  : AluIdle;
    end

    always_comb begin
        Ready = state != AluShift;
        Done  = state == AluDone;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc    <= '0;
            cnt    <= '0;
            shLeft <= 1'b0;
            Result <= '0;
            flags  <= '0;
        end else begin
            if (accept && isShift) begin
                acc    <= A;
                cnt    <= ShAmt;
                shLeft <= Func == FnLSL;
            end else if (state == AluShift) begin
                acc <= accNext;
                cnt <= cnt - SHAMT_W'(1);
            end
            if (accept && !isShift) begin
                Result <= oneRes;
                flags  <= oneFlags;
            end else if (lastShift) begin
                Result <= accNext;
                flags  <= shiftFlags;
            end
        end
    end

    assign FlagZ = flags.z;
    assign FlagN = flags.n;
    assign FlagC = flags.c;
    assign FlagV = flags.v;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle ALU for the datapath; next generation of the fixed single-cycle ALU.
- Adds configurable width, carry-in arithmetic (ADC/SBC), variable shift amounts and registered Z/N/C/V flags.
- Uses a start/ready/done handshake with the control FSM.
- Sits between the operand muxes (Op1 select, register file, sysbus) and the writeback/PC-select logic.

Parameters:
- WIDTH, 16, datapath width in bits (must be ≥ 4).
- SHAMT_W, 4, shift-amount port width. Must equal clog2(WIDTH).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request. Accepted only in a cycle where Ready=1.
- Func  in  4  alu_functions_t code. Sampled on accept.
- A  in  WIDTH  operand 1. Sampled on accept.
- B  in  WIDTH  operand 2 / memory data. Sampled on accept.
- CarryIn  in  1  carry for ADC/SBC. Sampled on accept.
- ShAmt  in  SHAMT_W  shift distance for LSL/LSR. Sampled on accept.
- Ready  out  1  can accept Start this cycle.
- Done  out  1  one-cycle pulse: Result and flags valid.
- Result  out  WIDTH  registered result. Held until the next accept completes.
- FlagZ, FlagN, FlagC, FlagV  out  1 each  registered flags. Updated together with Result.

Behaviour:
- Reset and clocking:
  - One clock (Clock). Reset is asynchronous and active-high.
  - Reset values: state=IDLE, Ready=1, Done=0, Result=0, all flags=0.
- States:
  - IDLE: Ready=1, Done=0.
  - SHIFT: Ready=0, Done=0.
  - DONE: Ready=1, Done=1.
- Accept: Start=1 while Ready=1 at edge t captures all inputs.
- Single-cycle functions (FnACC, FnMem, FnADD, FnSUB, FnADC, FnSBC, FnAND, FnOR, FnNOT, and shifts with ShAmt=0):
  - Result and flags are written at edge t. State goes to DONE.
  - Done=1 in cycle t+1. Latency 1.
- Shifts with ShAmt=k≥1:
  - At edge t, acc←A and cnt←k; state goes to SHIFT.
  - Each SHIFT cycle shifts acc one bit (zero fill), records the bit shifted out, and decrements cnt.
  - When cnt reaches 0, write Result/flags and go to DONE.
  - Done=1 in cycle t+k+1.
- From DONE: Start=1 is accepted (back-to-back); otherwise return to IDLE.
- Start while Ready=0 is ignored. No queuing, no error.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: A+B.
  - ADC: A+B+CarryIn.
  - SUB: A+~B+1.
  - SBC: A+~B+CarryIn.
  - C = adder carry-out (for SUB/SBC, 1 means no borrow).
  - V = signed overflow: operand MSBs equal, result MSB differs (for subtraction, use the inverted B MSB).
- Logic and passes: AND → A&B; OR → A|B; NOT → ~A; FnACC → A; FnMem → B. For these, C=0 and V=0.
- Shift flags: C = last bit shifted out (0 when ShAmt=0); V=0.
- FlagZ = (Result==0). FlagN = Result[WIDTH-1]. Both apply to every function.
- Undefined Func codes behave as FnACC.
- Reset mid-SHIFT: operation is aborted, state goes to reset values, and no Done pulse is produced.
- Result/flags are not modified during SHIFT; the previous values are held until the final write.

Decomposition:
- Package opcodes:
  - Extend alu_functions_t with FnADC=9 and FnSBC=10. Existing codes are unchanged.
  - Add alu_state_t {AluIdle, AluShift, AluDone}.
  - Add alu_flags_t packed struct {z,n,c,v}.
- One sub-module: alu_addsub.
  - Combinational, WIDTH-parametrised.
  - Inputs: a, b, cin, sub. Outputs: sum, cout, ovf.
  - Shared by ADD/ADC/SUB/SBC.
- The shifter and FSM stay in alu_seq.

Test Plan (WIDTH=16):
- ADD A=0x7FFF, B=0x0001 → Done at t+1; Result=0x8000; N=1, V=1, C=0, Z=0.
- SUB A=0x0005, B=0x0005 → Result=0x0000; Z=1, C=1, V=0, N=0. Then SBC A=0x0000, B=0x0000, CarryIn=0 → Result=0xFFFF, C=0, N=1.
- ADC A=0xFFFF, B=0x0000, CarryIn=1 → Result=0x0000; Z=1, C=1, V=0.
- LSL A=0x8001, ShAmt=3 → Ready=0 for 3 cycles; Done at t+4; Result=0x0008, C=0. LSR A=0x0005, ShAmt=1 → Done at t+2; Result=0x0002, C=1.
- Start pulsed during SHIFT → ignored, in-flight Result is correct. Start in the DONE cycle (AND 0x00F0, 0x0FF0) → Done the next cycle; Result=0x00F0.
- Reset asserted at the second SHIFT cycle of LSL ShAmt=8 → same cycle: Ready=1, Result=0, flags=0; no Done pulse afterwards.
